// File: rtl/fft_sched_pkg.sv
// Shared types and index math for the radix-2 DIT butterfly scheduler.
package fft_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_U,
        ST_RD_V,
        ST_EXEC,
        ST_WR_U,
        ST_WR_V,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [31:0] u;
        logic [31:0] v;
        logic [31:0] tw;
    } bfly_addr_t;

    // Full-width results; callers truncate to their port widths.
    function automatic bfly_addr_t bfly_addr(input int unsigned s, input int unsigned g,
                                             input int unsigned b, input int unsigned l);
        bfly_addr_t a;
        a.u  = (g << (s + 1)) | b;
        a.v  = a.u + (32'd1 << s);
        a.tw = b << (l - 1 - s);
        return a;
    endfunction

endpackage

// File: rtl/fft_bfly_cnt.sv
// Stage / group / butterfly counter nest; b innermost, s outermost.
module fft_bfly_cnt #(
    parameter int unsigned FFT_SIZE = 1024,
    localparam int unsigned L  = $clog2(FFT_SIZE),
    localparam int unsigned SW = $clog2(L),
    localparam int unsigned CW = L - 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic          last_o,
    output logic [SW-1:0] s_o,
    output logic [CW-1:0] g_o,
    output logic [CW-1:0] b_o
);

    logic [SW-1:0] s_q;
    logic [CW-1:0] g_q;
    logic [CW-1:0] b_q;
    logic [CW-1:0] b_max;
    logic [CW-1:0] g_max;
    logic          b_last;
    logic          g_last;
    logic          s_last;

    // 32-bit shift amount so s+1 cannot wrap when L is a power of two.
    always_comb begin
        b_max  = CW'((32'd1 << s_q) - 32'd1);
        g_max  = CW'((FFT_SIZE >> (32'(s_q) + 32'd1)) - 32'd1);
        b_last = (b_q == b_max);
        g_last = (g_q == g_max);
        s_last = (s_q == SW'(L - 1));
    end

    assign last_o = b_last && g_last && s_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (clr_i) begin
            s_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (adv_i) begin
            if (!b_last) begin
                b_q <= b_q + 1'b1;
            end else begin
                b_q <= '0;
                if (!g_last) begin
                    g_q <= g_q + 1'b1;
                end else begin
                    g_q <= '0;
                    s_q <= s_last ? '0 : s_q + 1'b1;
                end
            end
        end
    end

    assign s_o = s_q;
    assign g_o = g_q;
    assign b_o = b_q;

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT butterfly scheduler driving one single-port complex RAM.
//   state   | meaning
//   IDLE    | waiting for start_i, counters zero
//   RD_U    | read u, hold until grant
//   RD_V    | read v, hold until grant
//   EXEC    | datapath computes u', v' (one cycle)
//   WR_U    | write u', hold until grant
//   WR_V    | write v', hold until grant, then advance counters
//   DONE    | one-cycle done pulse
module fft_bfly_sched
    import fft_sched_pkg::*;
#(
    parameter int unsigned FFT_SIZE = 1024,
    localparam int unsigned L  = $clog2(FFT_SIZE),
    localparam int unsigned SW = $clog2(L)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    output logic          mem_we_o,
    output logic [L-1:0]  mem_addr_o,
    output logic          wr_sel_v_o,
    output logic          latch_u_o,
    output logic          latch_v_o,
    output logic [L-2:0]  tw_addr_o,
    output logic [SW-1:0] stage_o,
    output logic          busy_o,
    output logic          done_o
);

    sched_state_e  state_q;
    sched_state_e  state_d;
    logic          latch_u_q;
    logic          cnt_adv;
    logic          cnt_last;
    logic [SW-1:0] s_cnt;
    logic [L-2:0]  g_cnt;
    logic [L-2:0]  b_cnt;
    bfly_addr_t    ba;
    logic          unused_hi;

    fft_bfly_cnt #(
        .FFT_SIZE(FFT_SIZE)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (abort_i),
        .adv_i (cnt_adv),
        .last_o(cnt_last),
        .s_o   (s_cnt),
        .g_o   (g_cnt),
        .b_o   (b_cnt)
    );

    assign ba        = bfly_addr(32'(s_cnt), 32'(g_cnt), 32'(b_cnt), L);
    assign unused_hi = ^{ba.u[31:L], ba.v[31:L], ba.tw[31:L-1]};
    assign cnt_adv   = (state_q == ST_WR_V) && mem_gnt_i && !abort_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            latch_u_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            latch_u_q <= (state_q == ST_RD_U) && mem_gnt_i && !abort_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        wr_sel_v_o = 1'b0;
        latch_v_o  = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = ST_RD_U;
            end
            ST_RD_U: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ba.u[L-1:0];
                if (mem_gnt_i) state_d = ST_RD_V;
            end
            ST_RD_V: begin
                mem_req_o  = 1'b1;
                mem_addr_o = ba.v[L-1:0];
                if (mem_gnt_i) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                latch_v_o = 1'b1;
                state_d   = ST_WR_U;
            end
            ST_WR_U: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = ba.u[L-1:0];
                if (mem_gnt_i) state_d = ST_WR_V;
            end
            ST_WR_V: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = ba.v[L-1:0];
                wr_sel_v_o = 1'b1;
                if (mem_gnt_i) state_d = cnt_last ? ST_DONE : ST_RD_U;
            end
            ST_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        // Abort overrides start and any grant; a write granted this cycle still lands.
        if (abort_i) state_d = ST_IDLE;
    end

    assign latch_u_o = latch_u_q;
    assign tw_addr_o = ba.tw[L-2:0];
    assign stage_o   = s_cnt;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched with FFT_SIZE = 8: scoreboard of RAM accesses plus a butterfly table.
module tb_fft_bfly_sched;

    localparam int unsigned N   = 8;
    localparam int unsigned L   = 3;
    localparam int unsigned SW  = 2;
    localparam int unsigned TW  = L - 1;
    localparam int unsigned NBF = (N / 2) * L;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic          mem_we_o;
    logic [L-1:0]  mem_addr_o;
    logic          wr_sel_v_o;
    logic          latch_u_o;
    logic          latch_v_o;
    logic [TW-1:0] tw_addr_o;
    logic [SW-1:0] stage_o;
    logic          busy_o;
    logic          done_o;

    fft_bfly_sched #(.FFT_SIZE(N)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .mem_req_o (mem_req_o),
        .mem_gnt_i (mem_gnt_i),
        .mem_we_o  (mem_we_o),
        .mem_addr_o(mem_addr_o),
        .wr_sel_v_o(wr_sel_v_o),
        .latch_u_o (latch_u_o),
        .latch_v_o (latch_v_o),
        .tw_addr_o (tw_addr_o),
        .stage_o   (stage_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 rd u, 1 rd v, 2 wr u, 3 wr v
    typedef struct packed {
        logic [1:0]    kind;
        logic          we;
        logic [L-1:0]  addr;
        logic [TW-1:0] tw;
        logic [SW-1:0] stage;
    } acc_t;

    typedef struct {
        int s;
        int u;
        int v;
        int tw;
    } vec_t;

    acc_t exp_q[$];
    acc_t obs_q[$];
    acc_t ref_q[$];
    vec_t tbl[NBF];

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int lv_cnt   = 0;
    bit gnt_rand = 1'b0;

    logic         exp_lu     = 1'b0;
    logic         exp_lv     = 1'b0;
    logic         prev_stall = 1'b0;
    logic [L-1:0] prev_addr  = '0;
    logic         prev_we    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_acc(input logic [1:0] k, input logic we, input int addr, input int tw, input int s);
        acc_t a;
        a.kind  = k;
        a.we    = we;
        a.addr  = addr[L-1:0];
        a.tw    = tw[TW-1:0];
        a.stage = s[SW-1:0];
        exp_q.push_back(a);
    endtask

    task automatic push_trace();
        for (int s = 0; s < int'(L); s++)
            for (int g = 0; g < int'(N) / (2 ** (s + 1)); g++)
                for (int b = 0; b < 2 ** s; b++) begin
                    int u;
                    int v;
                    int tw;
                    u  = g * (2 ** (s + 1)) + b;
                    v  = u + 2 ** s;
                    tw = b * (2 ** (int'(L) - 1 - s));
                    push_acc(2'd0, 1'b0, u, tw, s);
                    push_acc(2'd1, 1'b0, v, tw, s);
                    push_acc(2'd2, 1'b1, u, tw, s);
                    push_acc(2'd3, 1'b1, v, tw, s);
                end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({mem_req_o, mem_we_o, mem_addr_o, wr_sel_v_o, latch_u_o, latch_v_o,
                    tw_addr_o, stage_o, busy_o, done_o});
    endfunction

    // Grant source: tied high or 50% random, changed just after each rising edge.
    initial begin
        mem_gnt_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk_i) begin
        acc_t e;
        acc_t a;
        if (!rst_ni) begin
            exp_lu     = 1'b0;
            exp_lv     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("latch_u", 32'(latch_u_o), 32'(exp_lu));
            chk("latch_v", 32'(latch_v_o), 32'(exp_lv));
            if (prev_stall && mem_req_o) begin
                chk("stall_addr", 32'(mem_addr_o), 32'(prev_addr));
                chk("stall_we", 32'(mem_we_o), 32'(prev_we));
            end
            if (!mem_req_o)
                chk("idle_bus", 32'({mem_we_o, mem_addr_o, wr_sel_v_o}), 32'd0);
            exp_lu = 1'b0;
            exp_lv = 1'b0;
            if (mem_req_o && mem_gnt_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 32'(mem_addr_o), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    a.kind  = e.kind;
                    a.we    = mem_we_o;
                    a.addr  = mem_addr_o;
                    a.tw    = tw_addr_o;
                    a.stage = stage_o;
                    obs_q.push_back(a);
                    chk("access", 32'({mem_we_o, mem_addr_o, tw_addr_o, stage_o}),
                        32'({e.we, e.addr, e.tw, e.stage}));
                    chk("wr_sel", 32'(wr_sel_v_o), 32'(e.kind == 2'd3));
                    exp_lu = (e.kind == 2'd0) && !abort_i;
                    exp_lv = (e.kind == 2'd1) && !abort_i;
                end
            end
            prev_stall = mem_req_o && !mem_gnt_i;
            prev_addr  = mem_addr_o;
            prev_we    = mem_we_o;
            if (done_o) done_cnt++;
            if (latch_v_o) lv_cnt++;
        end
    end

    task automatic start_pulse();
        @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic run_xfer(input bit timing, input bit extra_start);
        int c;
        int lv0;
        lv0 = lv_cnt;
        push_trace();
        start_pulse();
        c = 1;
        while (!done_o && c < 3000) begin
            @(posedge clk_i);
            #1;
            c++;
            start_i = extra_start && (c == 2 || c == 4);
        end
        start_i = 1'b0;
        chk("done_seen", 32'(done_o), 32'd1);
        if (timing) chk("done_cycle", 32'(c), 32'd61);
        chk("busy_at_done", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("busy_after", 32'(busy_o), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("latch_v_count", 32'(lv_cnt - lv0), 32'(NBF));
    endtask

    task automatic cmp_ref(input string name);
        chk({name, "_len"}, 32'(obs_q.size()), 32'(ref_q.size()));
        if (obs_q.size() == ref_q.size())
            for (int i = 0; i < obs_q.size(); i++)
                chk(name, 32'(obs_q[i]), 32'(ref_q[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tbl = '{'{0, 0, 1, 0}, '{0, 2, 3, 0}, '{0, 4, 5, 0}, '{0, 6, 7, 0},
                '{1, 0, 2, 0}, '{1, 1, 3, 2}, '{1, 4, 6, 0}, '{1, 5, 7, 2},
                '{2, 0, 4, 0}, '{2, 1, 5, 1}, '{2, 2, 6, 2}, '{2, 3, 7, 3}};
        rst_ni  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        #12;
        chk("reset_outputs", all_outs(), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("idle_after_reset", all_outs(), 32'd0);

        // Grant tied high: timing and the butterfly table.
        obs_q.delete();
        run_xfer(1'b1, 1'b0);
        chk("trace_len", 32'(obs_q.size()), 32'(4 * NBF));
        if (obs_q.size() == 4 * NBF)
            for (int k = 0; k < int'(NBF); k++) begin
                chk($sformatf("tbl_u[%0d]", k), 32'(obs_q[4*k].addr), 32'(tbl[k].u));
                chk($sformatf("tbl_v[%0d]", k), 32'(obs_q[4*k+1].addr), 32'(tbl[k].v));
                chk($sformatf("tbl_tw[%0d]", k), 32'(obs_q[4*k].tw), 32'(tbl[k].tw));
                chk($sformatf("tbl_stage[%0d]", k), 32'(obs_q[4*k].stage), 32'(tbl[k].s));
                chk($sformatf("tbl_wr[%0d]", k),
                    32'({obs_q[4*k+2].we, obs_q[4*k+2].addr, obs_q[4*k+3].we, obs_q[4*k+3].addr}),
                    32'({1'b1, 3'(tbl[k].u), 1'b1, 3'(tbl[k].v)}));
            end
        ref_q = obs_q;

        // Random grant withdrawal.
        obs_q.delete();
        gnt_rand = 1'b1;
        run_xfer(1'b0, 1'b0);
        gnt_rand = 1'b0;
        cmp_ref("rand_trace");

        // start_i pulsed during RD_V and WR_U of the first butterfly.
        obs_q.delete();
        run_xfer(1'b1, 1'b1);
        cmp_ref("start_busy_trace");

        // Abort in WR_U of butterfly 5 (u = 1).
        obs_q.delete();
        push_trace();
        d0 = done_cnt;
        start_pulse();
        repeat (28) @(posedge clk_i);
        #1;
        chk("abort_in_wr_u", 32'({mem_req_o, mem_we_o, wr_sel_v_o, mem_addr_o}),
            32'({1'b1, 1'b1, 1'b0, 3'd1}));
        abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        chk("abort_idle", 32'({busy_o, mem_req_o, stage_o, tw_addr_o}), 32'd0);
        chk("abort_write_done", 32'(obs_q.size()), 32'd23);
        repeat (5) @(posedge clk_i);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        exp_q.delete();
        obs_q.delete();
        run_xfer(1'b1, 1'b0);
        if (obs_q.size() > 0) chk("restart_u0", 32'(obs_q[0].addr), 32'd0);
        cmp_ref("restart_trace");

        // Asynchronous reset in stage 1.
        obs_q.delete();
        push_trace();
        d0 = done_cnt;
        start_pulse();
        repeat (25) @(posedge clk_i);
        #2;
        chk("pre_reset_stage", 32'(stage_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        exp_q.delete();
        obs_q.delete();
        repeat (5) @(posedge clk_i);
        #1;
        chk("idle_after_midreset", all_outs(), 32'd0);
        chk("midreset_no_done", 32'(done_cnt), 32'(d0));
        run_xfer(1'b1, 1'b0);
        cmp_ref("post_reset_trace");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
